// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle add/sub/and/or,
// multi-cycle shift-left with valid/ready handshake.
module alu_exec_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;

    logic             accept;
    logic             is_add;
    logic             is_sub;
    logic             is_and;
    logic             is_or;
    logic             is_sll;
    logic             is_legal;
    logic [SHW-1:0]   shamt;
    logic             sll_multi;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_next;
    logic             last_shift;

    assign accept     = in_valid && (state_q == IDLE);
    assign shamt      = b[SHW-1:0];
    assign is_add     = (Operation == OP_ADD);
    assign is_sub     = (Operation == OP_SUB);
    assign is_and     = (Operation == OP_AND);
    assign is_or      = (Operation == OP_OR);
    assign is_sll     = (Operation == OP_SLL);
    assign is_legal   = is_add | is_sub | is_and | is_or | is_sll;
    assign sll_multi  = is_sll && (shamt != '0);
    assign acc_next   = {acc_q[WIDTH-2:0], 1'b0};
    assign last_shift = (state_q == SHIFT) && (cnt_q == SHW'(1));

    // Single-cycle result for every op except a nonzero shift
    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            is_add:  alu_res = a + b;
            is_sub:  alu_res = a - b;
            is_and:  alu_res = a & b;
            is_or:   alu_res = a | b;
            is_sll:  alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = sll_multi ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Shift accumulator and remaining-count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (accept && sll_multi) begin
            acc_q <= a;
            cnt_q <= shamt;
        end else if (state_q == SHIFT) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q - SHW'(1);
        end
    end

    // Result flags change only on entry to DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept && !sll_multi) begin
            result_q  <= alu_res;
            zero_q    <= (alu_res == '0);
            illegal_q <= !is_legal;
        end else if (last_shift) begin
            result_q  <= acc_next;
            zero_q    <= (acc_next == '0);
            illegal_q <= 1'b0;
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_exec_unit;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Operation (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // present a request, let one edge accept it, then drop it
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // wait (bounded) for out_valid; n = extra edges after accept edge
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    int n;
    int seen;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'b0000;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        tick();
        reset = 1'b1;

        // ADD on first edge after release
        issue(4'b0010, 64'd5, 64'd7);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_result", result, 64'd12);
        chk("add_zero", 64'(zero), 64'd0);
        chk("add_illegal", 64'(illegal), 64'd0);
        tick();
        chk("add_back_ready", 64'(in_ready), 64'd1);
        chk("add_back_valid", 64'(out_valid), 64'd0);

        // SUB to zero
        issue(4'b0110, 64'd3, 64'd3);
        chk("sub0_result", result, 64'd0);
        chk("sub0_zero", 64'(zero), 64'd1);
        tick();

        // SUB wrap
        issue(4'b0110, 64'd0, 64'd1);
        chk("subw_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("subw_zero", 64'(zero), 64'd0);
        tick();

        // SLL by 63: result hidden while shifting
        issue(4'b1000, 64'd1, 64'd63);
        chk("sll63_busy_valid", 64'(out_valid), 64'd0);
        chk("sll63_busy_ready", 64'(in_ready), 64'd0);
        chk("sll63_busy_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(n);
        chk("sll63_latency", 64'(n + 1), 64'd64);
        chk("sll63_result", result, 64'h8000_0000_0000_0000);
        chk("sll63_zero", 64'(zero), 64'd0);
        tick();

        // SLL by 0
        issue(4'b1000, 64'hF, 64'd0);
        chk("sll0_valid", 64'(out_valid), 64'd1);
        chk("sll0_result", result, 64'hF);
        tick();

        // SLL by 5
        issue(4'b1000, 64'd3, 64'd5);
        wait_done(n);
        chk("sll5_latency", 64'(n + 1), 64'd6);
        chk("sll5_result", result, 64'h60);
        tick();

        // AND with downstream stall and ignored new request
        out_ready = 1'b0;
        issue(4'b0000, 64'hF0, 64'h3C);
        chk("and_result", result, 64'h30);
        op       = 4'b0010;
        a        = 64'd1;
        b        = 64'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_result", result, 64'h30);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_ready", 64'(in_ready), 64'd0);
        end
        // release with in_valid still high: no accept on this edge
        out_ready = 1'b1;
        tick();
        chk("rel_valid", 64'(out_valid), 64'd0);
        chk("rel_ready", 64'(in_ready), 64'd1);
        chk("rel_result", result, 64'h30);
        tick();
        in_valid = 1'b0;
        chk("held_add_result", result, 64'd2);
        chk("held_add_valid", 64'(out_valid), 64'd1);
        tick();

        // illegal op then OR
        issue(4'b0111, 64'd9, 64'd9);
        chk("ill_result", result, 64'd0);
        chk("ill_zero", 64'(zero), 64'd1);
        chk("ill_flag", 64'(illegal), 64'd1);
        tick();
        issue(4'b0001, 64'd1, 64'd2);
        chk("or_result", result, 64'd3);
        chk("or_illegal", 64'(illegal), 64'd0);
        chk("or_zero", 64'(zero), 64'd0);
        tick();

        // SLL aborted by reset mid-shift
        issue(4'b1000, 64'd1, 64'd10);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_pre_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        #1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_ready", 64'(in_ready), 64'd1);
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);
        chk("abort_idle_ready", 64'(in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
